// File: rtl/imem_pkg.sv
// Shared types, constants and address helpers for the synchronous instruction memory.
package imem_pkg;

  typedef enum logic {BOOT, RUN} imem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Word-aligned and inside the Depth-word window; all upper bits must be zero.
  function automatic logic addr_legal(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < (64'(depth) << 2));
  endfunction

endpackage

// File: rtl/imem_array.sv
// Depth x Word_size storage: one write port, one registered read port, no reset.
module imem_array #(
  parameter int unsigned Word_size = 32,
  parameter int unsigned Depth     = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Word_size-1:0]     i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Word_size-1:0]     o_rdata
);

  logic [Word_size-1:0] r_mem [Depth];
  logic [Word_size-1:0] r_rdata;

  // Read data only updates on an enabled read, so it holds between fetches.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/i_memory_sync.sv
// Clocked instruction memory: boot-time program load, then one-cycle registered fetches
// with stall hold and fault reporting for misaligned or out-of-range addresses.
module i_memory_sync #(
  parameter int unsigned          Word_size = 32,
  parameter int unsigned          Addr_bits = 32,
  parameter int unsigned          Depth     = 1024,
  parameter logic [Word_size-1:0] NOP_INSTR = Word_size'(imem_pkg::NOP_INSTR)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prog_we,
  input  logic [Addr_bits-1:0]       prog_addr,
  input  logic [Word_size-1:0]       prog_wdata,
  input  logic                       prog_done,
  input  logic                       fetch_req,
  input  logic [Addr_bits-1:0]       fetch_addr,
  input  logic                       fetch_stall,
  output logic                       fetch_valid,
  output logic [Word_size-1:0]       instr,
  output logic                       fetch_fault,
  output logic                       boot_busy,
  output logic [$clog2(Depth):0]     load_count
);

  import imem_pkg::*;

  localparam int unsigned IDX = $clog2(Depth);
  localparam int unsigned CW  = IDX + 1;

  imem_state_t          r_state;
  imem_state_t          w_state_next;
  logic                 r_valid;
  logic                 r_fault;
  logic                 r_use_mem;
  logic                 r_boot_busy;
  logic [CW-1:0]        r_count;
  logic                 w_valid_next;
  logic                 w_fault_next;
  logic                 w_use_mem_next;
  logic [CW-1:0]        w_count_next;
  logic                 w_we;
  logic                 w_re;
  logic                 w_prog_legal;
  logic                 w_fetch_legal;
  logic [IDX-1:0]       w_widx;
  logic [IDX-1:0]       w_ridx;
  logic [Word_size-1:0] w_rdata;

  assign w_prog_legal  = addr_legal(64'(prog_addr), Depth);
  assign w_fetch_legal = addr_legal(64'(fetch_addr), Depth);
  assign w_widx        = prog_addr[IDX+1:2];
  assign w_ridx        = fetch_addr[IDX+1:2];

  imem_array #(
    .Word_size (Word_size),
    .Depth     (Depth)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_widx),
    .i_wdata (prog_wdata),
    .i_re    (w_re),
    .i_raddr (w_ridx),
    .o_rdata (w_rdata)
  );

  // State register and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= BOOT;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
      r_use_mem   <= 1'b0;
      r_boot_busy <= 1'b1;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_valid     <= w_valid_next;
      r_fault     <= w_fault_next;
      r_use_mem   <= w_use_mem_next;
      r_boot_busy <= (w_state_next == BOOT);
      r_count     <= w_count_next;
    end
  end

  // Next state: BOOT leaves on prog_done; RUN is left only through reset.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    if (prog_done) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = BOOT;
    endcase
  end

  // Outputs and memory strobes; stall takes priority over a request.
  always_comb begin
    w_we           = 1'b0;
    w_re           = 1'b0;
    w_valid_next   = r_valid;
    w_fault_next   = r_fault;
    w_use_mem_next = r_use_mem;
    w_count_next   = r_count;
    case (r_state)
      BOOT: begin
        w_valid_next = 1'b0;
        w_fault_next = 1'b0;
        if (prog_we && w_prog_legal) begin
          w_we = 1'b1;
          if (r_count != CW'(Depth)) begin
            w_count_next = r_count + CW'(1);
          end
        end
      end
      RUN: begin
        if (!fetch_stall) begin
          if (fetch_req) begin
            w_valid_next   = 1'b1;
            w_fault_next   = !w_fetch_legal;
            w_use_mem_next = w_fetch_legal;
            w_re           = w_fetch_legal;
          end else begin
            w_valid_next = 1'b0;
            w_fault_next = 1'b0;
          end
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_fault_next = 1'b0;
      end
    endcase
  end

  assign fetch_valid = r_valid;
  assign fetch_fault = r_fault;
  assign instr       = r_use_mem ? w_rdata : NOP_INSTR;
  assign boot_busy   = r_boot_busy;
  assign load_count  = r_count;

endmodule

// File: tb/tb_i_memory_sync.sv
// Directed bench for i_memory_sync with a cycle-level reference model and per-cycle compare.
module tb_i_memory_sync;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        prog_done;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [31:0] instr;
  logic        fetch_fault;
  logic        boot_busy;
  logic [10:0] load_count;

  int n_tests = 0;
  int n_fail  = 0;

  i_memory_sync #(
    .Word_size (32),
    .Addr_bits (32),
    .Depth     (1024),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .prog_done   (prog_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_valid (fetch_valid),
    .instr       (instr),
    .fetch_fault (fetch_fault),
    .boot_busy   (boot_busy),
    .load_count  (load_count)
  );

  always #5 clk = ~clk;

  // Reference model: program held as a word-indexed table, outputs from the stated rules.
  logic [31:0] m_mem [int];
  bit          m_boot;
  int          m_count;
  bit          m_valid;
  bit          m_fault;
  logic [31:0] m_instr;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd4096);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_boot = 1; m_count = 0; m_valid = 0; m_fault = 0; m_instr = NOP;
    end else if (m_boot) begin
      if (prog_we && legal(prog_addr)) begin
        m_mem[int'(prog_addr / 4)] = prog_wdata;
        if (m_count < 1024) m_count = m_count + 1;
      end
      m_valid = 0;
      m_fault = 0;
      if (prog_done) m_boot = 0;
    end else if (!fetch_stall) begin
      if (fetch_req) begin
        m_valid = 1;
        if (legal(fetch_addr)) begin
          m_instr = m_mem[int'(fetch_addr / 4)];
          m_fault = 0;
        end else begin
          m_instr = NOP;
          m_fault = 1;
        end
      end else begin
        m_valid = 0;
        m_fault = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_valid", 64'(fetch_valid), 64'(m_valid));
      check("cyc_fault", 64'(fetch_fault), 64'(m_fault));
      check("cyc_instr", 64'(instr), 64'(m_instr));
      check("cyc_busy",  64'(boot_busy), 64'(m_boot));
      check("cyc_count", 64'(load_count), 64'(m_count));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic boot_write(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1; prog_addr = a; prog_wdata = d;
    step();
    prog_we = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1; fetch_addr = a;
    step();
  endtask

  initial begin
    reset = 1; prog_we = 0; prog_addr = '0; prog_wdata = '0; prog_done = 0;
    fetch_req = 0; fetch_addr = '0; fetch_stall = 0;
    step(); step();
    reset = 0;
    check("rst_valid", 64'(fetch_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'h13);
    check("rst_busy",  64'(boot_busy), 64'd1);
    check("rst_count", 64'(load_count), 64'd0);

    // Fetches during BOOT are ignored.
    fetch(32'h0); step();
    fetch_req = 0;
    check("boot_fetch_valid", 64'(fetch_valid), 64'd0);
    check("boot_fetch_instr", 64'(instr), 64'h13);
    check("boot_fetch_busy",  64'(boot_busy), 64'd1);

    boot_write(32'h0, 32'h0000_0093);
    boot_write(32'h4, 32'h0010_0193);
    boot_write(32'h8, 32'h0000_a103);
    boot_write(32'h2, 32'hdead_beef);
    check("misaligned_write_count", 64'(load_count), 64'd3);
    boot_write(32'h1000, 32'hdead_beef);
    check("oor_write_count", 64'(load_count), 64'd3);

    prog_done = 1;
    check("busy_before_done_edge", 64'(boot_busy), 64'd1);
    step();
    prog_done = 0;
    check("busy_after_done", 64'(boot_busy), 64'd0);
    check("count_after_boot", 64'(load_count), 64'd3);

    // Back-to-back fetches.
    fetch(32'h0);
    check("f0_instr", 64'(instr), 64'h0000_0093);
    check("f0_valid", 64'(fetch_valid), 64'd1);
    fetch(32'h4);
    check("f4_instr", 64'(instr), 64'h0010_0193);
    fetch(32'h8);
    check("f8_instr", 64'(instr), 64'h0000_a103);
    check("f8_valid", 64'(fetch_valid), 64'd1);

    fetch(32'h6);
    check("mis_fault", 64'(fetch_fault), 64'd1);
    check("mis_instr", 64'(instr), 64'h13);
    check("mis_valid", 64'(fetch_valid), 64'd1);
    fetch(32'h1000);
    check("oor_fault", 64'(fetch_fault), 64'd1);
    check("oor_instr", 64'(instr), 64'h13);
    fetch_req = 0;
    step();
    check("idle_valid", 64'(fetch_valid), 64'd0);
    check("idle_fault", 64'(fetch_fault), 64'd0);

    // Stall holds outputs even with a request pending.
    fetch(32'h4);
    fetch_stall = 1; fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", 64'(instr), 64'h0010_0193);
      check("stall_valid", 64'(fetch_valid), 64'd1);
    end
    fetch_stall = 0;
    fetch(32'h8);
    check("unstall_instr", 64'(instr), 64'h0000_a103);
    fetch_req = 0;
    step();
    check("idle_hold_instr", 64'(instr), 64'h0000_a103);

    // Program port is inert in RUN.
    boot_write(32'h0, 32'hffff_ffff);
    check("run_write_count", 64'(load_count), 64'd3);
    fetch(32'h0);
    check("run_write_dropped", 64'(instr), 64'h0000_0093);
    fetch_req = 0;

    // Reset mid-RUN: outputs reset asynchronously, memory retained.
    reset = 1;
    #2;
    check("async_rst_valid", 64'(fetch_valid), 64'd0);
    check("async_rst_busy",  64'(boot_busy), 64'd1);
    check("async_rst_count", 64'(load_count), 64'd0);
    check("async_rst_instr", 64'(instr), 64'h13);
    step();
    reset = 0;
    prog_done = 1;
    step();
    prog_done = 0;
    fetch(32'h0);
    check("retained_instr", 64'(instr), 64'h0000_0093);
    check("retained_count", 64'(load_count), 64'd0);
    fetch_req = 0;

    // Count saturation and the last legal word.
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 1030; i++) begin
      boot_write(32'((i % 1024) * 4), 32'(i) ^ 32'h5a00_0000);
    end
    check("sat_count", 64'(load_count), 64'd1024);
    prog_done = 1; step(); prog_done = 0;
    fetch(32'hffc);
    check("last_word", 64'(instr), 64'h5a00_03ff);
    check("last_fault", 64'(fetch_fault), 64'd0);
    fetch(32'h0);
    check("rewritten_word0", 64'(instr), 64'h5a00_0400);
    fetch_req = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
